// File: rtl/seg7_pkg.sv
// Shared constants, event bundle and segment-pattern to ASCII decode
// for the 7-segment bus monitor.
package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_BLANK     = 7'b0000000;
  localparam logic [6:0] ASCII_SPACE   = 7'h20;
  localparam logic [6:0] ASCII_UNKNOWN = 7'h7F;

  typedef struct packed {
    logic [6:0] ascii;
    logic       dp;
    logic [2:0] idx;
  } char_evt_t;

  // Inverse of the forward font; lowercase-only shapes map to uppercase.
  function automatic logic [6:0] seg7_decode(input logic [6:0] seg);
    logic [6:0] a;
    unique case (seg)
      7'h3F:     a = 7'h30;
      7'h06:     a = 7'h31;
      7'h5B:     a = 7'h32;
      7'h4F:     a = 7'h33;
      7'h66:     a = 7'h34;
      7'h6D:     a = 7'h35;
      7'h7D:     a = 7'h36;
      7'h07:     a = 7'h37;
      7'h7F:     a = 7'h38;
      7'h6F:     a = 7'h39;
      7'h77:     a = 7'h41;
      7'h39:     a = 7'h43;
      7'h79:     a = 7'h45;
      7'h71:     a = 7'h46;
      7'h3D:     a = 7'h47;
      7'h76:     a = 7'h48;
      7'h1E:     a = 7'h4A;
      7'h38:     a = 7'h4C;
      7'h73:     a = 7'h50;
      7'h3E:     a = 7'h55;
      7'h6E:     a = 7'h59;
      7'h7C:     a = 7'h42;
      7'h5E:     a = 7'h44;
      7'h74:     a = 7'h48;
      7'h54:     a = 7'h4E;
      7'h5C:     a = 7'h4F;
      7'h50:     a = 7'h52;
      7'h78:     a = 7'h54;
      7'h1C:     a = 7'h55;
      SEG_BLANK: a = ASCII_SPACE;
      default:   a = ASCII_UNKNOWN;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational gfedcba pattern to 7-bit ASCII lookup.
// Thin wrapper so the decode table sits behind one instance.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [6:0] ascii
);

  assign ascii = seg7_decode(pattern);

endmodule

// File: rtl/seg7_bus_to_ascii_monitor.sv
// Passive multiplexed 7-seg bus monitor: per-digit capture, change detect, event output.
// Define SEG7_MON_GLITCH_CNT_EN to add the glitch_cnt short-window counter port.
module seg7_bus_to_ascii_monitor
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            Segments,
  input  logic                  dp,
  input  logic [NUM_DIGITS-1:0] SEL,
  output logic [6:0]            char_ascii,
  output logic                  char_dp,
  output logic [2:0]            char_idx,
  output logic                  char_valid,
  input  logic                  char_ready
`ifdef SEG7_MON_GLITCH_CNT_EN
  ,
  output logic [15:0]           glitch_cnt
`endif
);

  localparam int SW = NUM_DIGITS + 8;
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [SW-1:0] SAMP_RST = {{NUM_DIGITS{1'b1}}, 8'h00};
  localparam logic [7:0] ENT_RST = {ASCII_SPACE, 1'b0};
  localparam char_evt_t OUT_RST = '{ascii: ASCII_SPACE, dp: 1'b0, idx: 3'd0};

  logic [SW-1:0] samp_q, samp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done_q, done_d;
  logic [NUM_DIGITS-1:0][7:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] seen_q, seen_d;
  logic [NUM_DIGITS-1:0] pend_q, pend_d;
  char_evt_t out_q, out_d;
  logic valid_q, valid_d;

  logic [NUM_DIGITS-1:0] sel_q;
  logic [NUM_DIGITS-1:0] pend_set, pend_clr;
  logic stay, capture, take;
  logic [6:0] cap_ascii;
  logic [7:0] cap_ent;

  assign samp_d  = {SEL, dp, Segments};
  assign sel_q   = samp_q[SW-1:8];
  assign stay    = $onehot(~SEL) && (samp_d == samp_q);
  assign cap_ent = {cap_ascii, samp_q[7]};

  seg7_pattern_decode u_dec (
    .pattern (samp_q[6:0]),
    .ascii   (cap_ascii)
  );

  always_comb begin
    cnt_d   = '0;
    done_d  = 1'b0;
    capture = 1'b0;
    if (stay) begin
      cnt_d   = (cnt_q == CNT_CAP) ? cnt_q : cnt_q + CNT_ONE;
      capture = (cnt_d == CNT_CAP) && !done_q;
      done_d  = done_q || capture;
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    seen_d   = seen_q;
    pend_set = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (capture && !sel_q[i]) begin
        seen_d[i] = 1'b1;
        if (!seen_q[i] || shadow_q[i] != cap_ent) begin
          shadow_d[i] = cap_ent;
          pend_set[i] = 1'b1;
        end
      end
    end
  end

  // Lowest index wins; a fresh capture re-arms pending over the clear.
  always_comb begin
    take     = !valid_q || char_ready;
    pend_clr = '0;
    out_d    = out_q;
    valid_d  = valid_q;
    if (take) begin
      valid_d = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
        if (pend_q[i]) begin
          valid_d     = 1'b1;
          pend_clr    = '0;
          pend_clr[i] = 1'b1;
          out_d       = '{ascii: shadow_q[i][7:1],
                          dp:    shadow_q[i][0],
                          idx:   3'(i)};
        end
      end
    end
    pend_d = (pend_q & ~pend_clr) | pend_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q   <= SAMP_RST;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      shadow_q <= {NUM_DIGITS{ENT_RST}};
      seen_q   <= '0;
      pend_q   <= '0;
      out_q    <= OUT_RST;
      valid_q  <= 1'b0;
    end else begin
      samp_q   <= samp_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      shadow_q <= shadow_d;
      seen_q   <= seen_d;
      pend_q   <= pend_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
    end
  end

  assign char_ascii = out_q.ascii;
  assign char_dp    = out_q.dp;
  assign char_idx   = out_q.idx;
  assign char_valid = valid_q;

`ifdef SEG7_MON_GLITCH_CNT_EN
  logic [15:0] glitch_q, glitch_d;
  logic win_end;

  assign win_end  = $onehot(~sel_q) && !stay && !done_q;
  assign glitch_d = (win_end && glitch_q != 16'hFFFF)
                  ? glitch_q + 16'd1 : glitch_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) glitch_q <= '0;
    else        glitch_q <= glitch_d;
  end

  assign glitch_cnt = glitch_q;
`endif

endmodule
